// File: rtl/aes_flow_if.sv
// Bundle of the sequencer's data-path and handshake signals.
// The slave modport is the controller's view. The master modport is the
// surrounding logic: deserialiser, key receiver, AES core and tx_fifo.
interface aes_flow_if #(
    parameter int DATA_W = 128,
    parameter int DROP_W = 8
);
    logic              key_write;
    logic [DATA_W-1:0] key_data;
    logic              key_clear;
    logic              atd_ready;
    logic [DATA_W-1:0] atd_data;
    logic              aes_start;
    logic [DATA_W-1:0] aes_key;
    logic [DATA_W-1:0] aes_din;
    logic              aes_done;
    logic [DATA_W-1:0] aes_dout;
    logic              fifo_full;
    logic              fifo_wr;
    logic [DATA_W-1:0] fifo_wdata;
    logic              key_loaded;
    logic              busy;
    logic [DROP_W-1:0] drop_cnt;

    modport slave (
        input  key_write, key_data, key_clear, atd_ready, atd_data,
               aes_done, aes_dout, fifo_full,
        output aes_start, aes_key, aes_din, fifo_wr, fifo_wdata,
               key_loaded, busy, drop_cnt
    );

    modport master (
        output key_write, key_data, key_clear, atd_ready, atd_data,
               aes_done, aes_dout, fifo_full,
        input  aes_start, aes_key, aes_din, fifo_wr, fifo_wdata,
               key_loaded, busy, drop_cnt
    );
endinterface

// File: rtl/aes_flow_ctrl.sv
// Sequencer between the ATD deserialiser, the AES-128 core and the I2C tx_fifo.
// It holds the active key, a shadow key and a one-block pending buffer.
//
//  state | meaning
//  NOKEY | no valid key; pending block is retained
//  IDLE  | key valid, waiting for a block
//  START | aes_start pulse, plaintext presented to core
//  RUN   | core busy, waiting for aes_done
//  WRITE | result ready, write to tx_fifo if not full
//  STALL | result held while tx_fifo is full
module aes_flow_ctrl #(
    parameter int DATA_W = 128,
    parameter int DROP_W = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    aes_flow_if.slave   bus
);
    typedef enum logic [2:0] {NOKEY, IDLE, START, RUN, WRITE, STALL} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] key_q, shadow_q, pend_q, din_q, result_q;
    logic              key_loaded_q, shadow_vld_q, pend_vld_q, start_q;
    logic [DROP_W-1:0] drop_q;

    logic busy_st, key_ok, go_d, consume_d, bypass_d, fifo_wr_d, to_idle_d;

    // Decode of handshake conditions shared by the state, key and intake logic
    always_comb begin
        busy_st   = (state_q == START) || (state_q == RUN) ||
                    (state_q == WRITE) || (state_q == STALL);
        // key_write wins over key_clear; a clear in this cycle blocks a start
        key_ok    = bus.key_write || (key_loaded_q && !bus.key_clear);
        go_d      = (state_q == IDLE) && key_ok && (pend_vld_q || bus.atd_ready);
        consume_d = go_d && pend_vld_q;
        // an arriving block with an empty buffer goes straight to the core
        bypass_d  = go_d && !pend_vld_q;
        // gated by fifo_full directly so a write never lands on a full FIFO
        fifo_wr_d = ((state_q == WRITE) || (state_q == STALL)) && !bus.fifo_full;
        to_idle_d = fifo_wr_d;
    end

    // Main sequencing FSM with registered start strobe, plaintext and result
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= NOKEY;
            start_q  <= 1'b0;
            din_q    <= '0;
            result_q <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                NOKEY: if (key_ok) state_q <= IDLE;
                IDLE: begin
                    if (!key_ok) begin
                        state_q <= NOKEY;
                    end else if (go_d) begin
                        state_q <= START;
                        start_q <= 1'b1;
                        din_q   <= pend_vld_q ? pend_q : bus.atd_data;
                    end
                end
                START: state_q <= RUN;
                RUN: begin
                    if (bus.aes_done) begin
                        result_q <= bus.aes_dout;
                        state_q  <= WRITE;
                    end
                end
                WRITE: state_q <= bus.fifo_full ? STALL : IDLE;
                STALL: if (!bus.fifo_full) state_q <= IDLE;
                default: state_q <= NOKEY;
            endcase
        end
    end

    // Active/shadow key: updates during an operation wait for the return to IDLE
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            key_q        <= '0;
            shadow_q     <= '0;
            key_loaded_q <= 1'b0;
            shadow_vld_q <= 1'b0;
        end else if (bus.key_write) begin
            if (busy_st && !to_idle_d) begin
                shadow_q     <= bus.key_data;
                shadow_vld_q <= 1'b1;
            end else begin
                key_q        <= bus.key_data;
                key_loaded_q <= 1'b1;
                shadow_vld_q <= 1'b0;
            end
        end else if (bus.key_clear) begin
            key_loaded_q <= 1'b0;
            shadow_vld_q <= 1'b0;
        end else if (to_idle_d && shadow_vld_q) begin
            key_q        <= shadow_q;
            key_loaded_q <= 1'b1;
            shadow_vld_q <= 1'b0;
        end
    end

    // Pending block buffer and saturating overrun counter
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            drop_q     <= '0;
        end else if (bus.atd_ready) begin
            if (pend_vld_q && !consume_d) begin
                if (drop_q != {DROP_W{1'b1}})
                    drop_q <= drop_q + {{(DROP_W-1){1'b0}}, 1'b1};
            end else if (!bypass_d) begin
                pend_q     <= bus.atd_data;
                pend_vld_q <= 1'b1;
            end
        end else if (consume_d) begin
            pend_vld_q <= 1'b0;
        end
    end

    assign bus.aes_start  = start_q;
    assign bus.aes_key    = key_q;
    assign bus.aes_din    = din_q;
    assign bus.fifo_wr    = fifo_wr_d;
    assign bus.fifo_wdata = result_q;
    assign bus.key_loaded = key_loaded_q;
    assign bus.busy       = busy_st;
    assign bus.drop_cnt   = drop_q;
endmodule

// File: tb/tb_aes_flow_ctrl.sv
// Directed bench for aes_flow_ctrl with an AES core stub (done 11 cycles
// after start, dout = din ^ key) and a scoreboard of expected ciphertexts.
module tb_aes_flow_ctrl;
    localparam logic [127:0] K1  = 128'h746869736973616b6579666561726d65;
    localparam logic [127:0] K2  = 128'h303132746865736b666164666a383132;
    localparam logic [127:0] K3  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] B1  = 128'h1234567890abcdef1234567890abcdef;
    localparam logic [127:0] B2  = 128'h1712419abed81821378dabce998af893;
    localparam logic [127:0] B3  = 128'hdeadbeef00112233445566778899aabb;
    localparam logic [127:0] B4  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] B5  = 128'hcafef00d55aa55aa1111222233334444;
    localparam logic [127:0] B8  = 128'h89abcdef01234567aaaabbbbccccdddd;
    localparam logic [127:0] B9  = 128'h5555666677778888999900001111ffff;
    localparam logic [127:0] B10 = 128'hfedcba98765432100123456789abcdef;
    localparam logic [127:0] B11 = 128'h13579bdf2468ace013579bdf2468ace0;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    aes_flow_if #(.DATA_W(128), .DROP_W(8)) bus ();
    aes_flow_ctrl #(.DATA_W(128), .DROP_W(8)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    int tests = 0, failed = 0;
    int ncyc = 0, t_start = 0, t_wr = 0, start_cnt = 0, wr_cnt = 0, wr_exp = 0;
    int s0, b4_wr;
    logic [127:0] sb_q[$];
    logic [127:0] stub_v;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_atd(input logic [127:0] d);
        bus.atd_data = d; bus.atd_ready = 1'b1;
        tick(1);
        bus.atd_ready = 1'b0;
    endtask

    task automatic pulse_key(input logic [127:0] d, input logic wr, input logic clr);
        bus.key_data = d; bus.key_write = wr; bus.key_clear = clr;
        tick(1);
        bus.key_write = 1'b0; bus.key_clear = 1'b0;
    endtask

    task automatic wait_wr(input int target);
        int n = 0;
        while (wr_cnt < target && n < 60) begin @(negedge clk); n++; end
        check("wr_arrived", wr_cnt, target);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, bus.aes_start, 0);
        check({tag, "_wr"}, bus.fifo_wr, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_key_loaded"}, bus.key_loaded, 0);
        check({tag, "_drop"}, bus.drop_cnt, 0);
        check({tag, "_aes_key"}, bus.aes_key, 0);
        check({tag, "_aes_din"}, bus.aes_din, 0);
        check({tag, "_wdata"}, bus.fifo_wdata, 0);
    endtask

    // AES core stub
    initial begin
        bus.aes_done = 1'b0; bus.aes_dout = '0;
        forever begin
            @(negedge clk);
            if (bus.aes_start === 1'b1) begin
                stub_v = bus.aes_din ^ bus.aes_key;
                repeat (11) @(posedge clk);
                #1 bus.aes_done = 1'b1; bus.aes_dout = stub_v;
                @(posedge clk);
                #1 bus.aes_done = 1'b0;
            end
        end
    end

    // Output monitor: scoreboard pop on every FIFO write
    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (bus.aes_start === 1'b1) begin t_start = ncyc; start_cnt++; end
            if (bus.fifo_wr === 1'b1) begin
                check("wr_not_full", bus.fifo_full, 0);
                check("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) check("wdata", bus.fifo_wdata, sb_q.pop_front());
                t_wr = ncyc;
                wr_cnt++;
            end
        end
    end

    initial begin
        n_rst = 1'b0;
        bus.key_write = 0; bus.key_data = '0; bus.key_clear = 0;
        bus.atd_ready = 0; bus.atd_data = '0; bus.fifo_full = 0;
        tick(2);
        @(negedge clk);
        check_all_zero("reset");
        tick(1);
        n_rst = 1'b1;
        tick(1);

        // key path
        pulse_key(K1, 1, 0);
        @(negedge clk);
        check("key_loaded_set", bus.key_loaded, 1);
        tick(1);
        sb_q.push_back(B1 ^ K1); wr_exp++;
        pulse_atd(B1);
        @(negedge clk);
        check("start_latency", bus.aes_start, 1);
        check("busy_in_start", bus.busy, 1);
        wait_wr(wr_exp);
        check("done_to_wr_latency", t_wr - t_start, 12);
        tick(1);

        // no-key hold
        pulse_key('0, 0, 1);
        @(negedge clk);
        check("key_clear", bus.key_loaded, 0);
        tick(1);
        s0 = start_cnt;
        pulse_atd(B2);
        tick(15);
        @(negedge clk);
        check("nokey_no_start", start_cnt, s0);
        check("nokey_not_busy", bus.busy, 0);
        tick(1);
        sb_q.push_back(B2 ^ K2); wr_exp++;
        pulse_key(K2, 1, 0);
        @(negedge clk);
        @(negedge clk);
        check("start_after_key", start_cnt, s0 + 1);
        wait_wr(wr_exp);
        tick(1);

        // FIFO stall
        bus.fifo_full = 1'b1;
        sb_q.push_back(B3 ^ K2);
        pulse_atd(B3);
        tick(15);
        tick(20);
        @(negedge clk);
        check("stall_no_wr", wr_cnt, wr_exp);
        check("stall_busy", bus.busy, 1);
        tick(1);
        bus.fifo_full = 1'b0; wr_exp++;
        wait_wr(wr_exp);
        tick(5);
        @(negedge clk);
        check("stall_single_wr", wr_cnt, wr_exp);
        check("idle_after_stall", bus.busy, 0);
        tick(1);

        // overrun
        bus.fifo_full = 1'b1;
        sb_q.push_back(B4 ^ K2);
        pulse_atd(B4);
        tick(3);
        sb_q.push_back(B5 ^ K2);
        pulse_atd(B5); tick(1);
        pulse_atd(~B5); tick(1);
        pulse_atd(B3);
        @(negedge clk);
        check("drop_cnt_2", bus.drop_cnt, 2);
        tick(1);
        for (int i = 0; i < 255; i++) begin
            pulse_atd({4{$urandom}});
            tick(1);
        end
        @(negedge clk);
        check("drop_cnt_sat", bus.drop_cnt, 8'hFF);
        tick(1);
        bus.fifo_full = 1'b0; wr_exp++;
        wait_wr(wr_exp);
        b4_wr = t_wr;
        wr_exp++;
        wait_wr(wr_exp);
        check("back_to_back_start", t_start - b4_wr, 2);
        tick(1);

        // key update mid-run
        sb_q.push_back(B8 ^ K2);
        pulse_atd(B8);
        tick(4);
        pulse_key(K3, 1, 0);
        sb_q.push_back(B9 ^ K3);
        pulse_atd(B9);
        wr_exp += 2;
        wait_wr(wr_exp);
        tick(1);
        pulse_key(K1, 1, 1);
        @(negedge clk);
        check("write_beats_clear", bus.key_loaded, 1);
        tick(1);
        sb_q.push_back(B10 ^ K1); wr_exp++;
        pulse_atd(B10);
        wait_wr(wr_exp);
        tick(1);

        // key clear while running: in-flight block still written
        sb_q.push_back(B11 ^ K1); wr_exp++;
        pulse_atd(B11);
        tick(4);
        pulse_key('0, 0, 1);
        @(negedge clk);
        check("clear_mid_run", bus.key_loaded, 0);
        wait_wr(wr_exp);
        tick(1);

        // asynchronous reset mid-run
        pulse_key(K2, 1, 0);
        tick(1);
        pulse_atd(B1);
        tick(5);
        n_rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick(2);
        n_rst = 1'b1;
        s0 = wr_cnt;
        tick(20);
        @(negedge clk);
        check("rst_no_wr", wr_cnt, s0);
        check("rst_drop_cnt", bus.drop_cnt, 0);
        check("rst_idle", bus.busy, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
